// File: rtl/dice_reader.sv
// dice_reader: settles and decodes the 7-LED dice pattern (led, clr in; face/face_valid/bad_pulse/bad_seen/sum/rolls/busy out)
module dice_reader #(
  parameter int STABLE_CYCLES = 2700000,
  parameter int CNT_W = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] led,
  input  logic       clr,
  output logic [2:0] face,
  output logic       face_valid,
  output logic       bad_pulse,
  output logic       bad_seen,
  output logic [9:0] sum,
  output logic [7:0] rolls,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  state_t state, state_d;
  logic [6:0] pattern_q, prev_q;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0] value;
  logic [10:0] sum_add;
  logic [9:0] sum_sat;
  logic change, blank, done, rep_ok, rep_bad;
  always_comb begin
    value = pattern_q == 7'b0001000 ? 3'd1 :
            pattern_q == 7'b0010100 ? 3'd2 :
            pattern_q == 7'b0011100 ? 3'd3 :
            pattern_q == 7'b0110110 ? 3'd4 :
            pattern_q == 7'b0111110 ? 3'd5 :
            pattern_q == 7'b1110111 ? 3'd6 : 3'd0;
    blank = pattern_q == 7'd0;
    change = pattern_q != prev_q;
    done = state == SETTLE && !change && cnt == CNT_W'(STABLE_CYCLES - 1);
    rep_ok = done && value != 3'd0;
    rep_bad = done && value == 3'd0;
    state_d = change ? (blank ? IDLE : SETTLE) : done ? HELD : state;
    cnt_d = change ? '0 : state == SETTLE ? cnt + 1'b1 : cnt;
    sum_add = {1'b0, sum} + {8'd0, value};
    sum_sat = sum_add[10] ? 10'h3ff : sum_add[9:0];
  end
  assign busy = state == SETTLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pattern_q <= '0;
      prev_q <= '0;
      cnt <= '0;
      face <= '0;
      face_valid <= 1'b0;
      bad_pulse <= 1'b0;
      bad_seen <= 1'b0;
      sum <= '0;
      rolls <= '0;
    end else begin
      pattern_q <= led;
      prev_q <= pattern_q;
      cnt <= cnt_d;
      face_valid <= rep_ok;
      bad_pulse <= rep_bad;
      bad_seen <= !clr && (bad_seen || rep_bad);
      face <= rep_ok ? value : clr ? 3'd0 : face;
      sum <= clr ? '0 : rep_ok ? sum_sat : sum;
      rolls <= clr ? '0 : rolls + 8'(rep_ok);
    end
endmodule

// File: tb/tb_dice_reader.sv
// tb_dice_reader: randomized and directed check of dice_reader against a run-length reference model
module tb_dice_reader;
  localparam int S = 4;
  logic clk, reset, clr, face_valid, bad_pulse, bad_seen, busy;
  logic [6:0] led;
  logic [2:0] face;
  logic [9:0] sum;
  logic [7:0] rolls;
  int vectors = 0, miscompares = 0;
  logic [6:0] m_v;
  int m_len, e_face, e_fv, e_bp, e_bad, e_sum, e_rolls, e_busy;
  logic [6:0] pats [6] = '{7'b0001000, 7'b0010100, 7'b0011100, 7'b0110110, 7'b0111110, 7'b1110111};
  dice_reader #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .led(led), .clr(clr), .face(face), .face_valid(face_valid),
    .bad_pulse(bad_pulse), .bad_seen(bad_seen), .sum(sum), .rolls(rolls), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 6; i++) if (p == pats[i]) return i + 1;
    return 0;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_v = '0; m_len = 1000;
    e_face = 0; e_fv = 0; e_bp = 0; e_bad = 0; e_sum = 0; e_rolls = 0; e_busy = 0;
  endtask
  // A value is reported once it has been sampled S+1 edges in a row.
  task automatic model_edge();
    int d;
    d = dec(m_v);
    e_fv = 0; e_bp = 0;
    if (m_v != 0 && m_len == S + 1) begin
      if (d > 0) begin
        e_fv = 1; e_face = d;
        e_sum = (e_sum + d > 1023) ? 1023 : e_sum + d;
        e_rolls = (e_rolls + 1) % 256;
      end else begin
        e_bp = 1; e_bad = 1;
      end
    end
    if (clr) begin
      e_sum = 0; e_rolls = 0; e_bad = 0;
      if (e_fv == 0) e_face = 0;
    end
    e_busy = (m_v != 0 && m_len <= S) ? 1 : 0;
    if (led == m_v) m_len = (m_len < 1000) ? m_len + 1 : 1000;
    else begin m_v = led; m_len = 1; end
  endtask
  task automatic check_all();
    chk("face", int'(face), e_face);
    chk("face_valid", int'(face_valid), e_fv);
    chk("bad_pulse", int'(bad_pulse), e_bp);
    chk("bad_seen", int'(bad_seen), e_bad);
    chk("sum", int'(sum), e_sum);
    chk("rolls", int'(rolls), e_rolls);
    chk("busy", int'(busy), e_busy);
  endtask
  task automatic step(input logic [6:0] l, input logic c);
    led = l; clr = c;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask
  task automatic hold(input logic [6:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask
  initial begin
    int pulses;
    logic [6:0] p;
    reset = 1; led = '0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    check_all();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(7'b0011100, 1'b0);
      pulses += int'(face_valid);
    end
    chk("single_pulse3", pulses, 1);
    chk("face3", int'(face), 3);
    hold(7'b0110110, 3);
    hold(7'b0111110, 12);
    chk("face5", int'(face), 5);
    chk("sum8", int'(sum), 8);
    hold(7'b1010101, 10);
    chk("bad_seen", int'(bad_seen), 1);
    step(7'b1010101, 1'b1);
    chk("clr_sum", int'(sum), 0);
    hold(7'b0000000, 3);
    for (int r = 0; r < 256; r++) begin
      hold(7'b1110111, 6);
      hold(7'b0000000, 3);
      if (r == 170) chk("sat171", int'(sum), 1023);
    end
    chk("sat_end", int'(sum), 1023);
    chk("rolls_wrap", int'(rolls), 0);
    hold(7'b0001000, 4);
    #2 reset = 1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #4 reset = 0;
    hold(7'b0001000, 8);
    chk("post_reset_face", int'(face), 1);
    chk("post_reset_rolls", int'(rolls), 1);
    hold(7'b0000000, 3);
    hold(7'b0010100, 5);
    step(7'b0010100, 1'b1);
    chk("clr_fv", int'(face_valid), 1);
    chk("clr_face", int'(face), 2);
    chk("clr_rolls", int'(rolls), 0);
    hold(7'b0010100, 3);
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1: p = '0;
        2: p = 7'($urandom);
        default: p = pats[$urandom_range(0, 5)];
      endcase
      for (int j = 0, n = $urandom_range(1, 9); j < n; j++) step(p, 1'($urandom_range(0, 19) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
